// File: rtl/load_gen_pkg.sv
// Shared definitions for the ramped LFSR load generator: LFSR geometry,
// ramp FSM state encoding and the per-lane seed derivation.
package load_gen_pkg;

    localparam int LFSR_W      = 49;
    localparam int TAP_HI      = 48;
    localparam int TAP_LO      = 39;
    localparam int SEED_STRIDE = 7;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RAMP_UP   = 2'd1,
        HOLD      = 2'd2,
        RAMP_DOWN = 2'd3
    } state_t;

    // Seed for a lane: base + idx*stride (mod 2^49); an all-zero LFSR would
    // lock up, so zero is replaced by 1.
    function automatic logic [LFSR_W-1:0] lane_seed(input logic [LFSR_W-1:0] base,
                                                    input int unsigned       idx);
        logic [LFSR_W-1:0] s;
        s = base + LFSR_W'(idx) * LFSR_W'(SEED_STRIDE);
        if (s == '0) begin
            s = LFSR_W'(1);
        end
        return s;
    endfunction

endpackage

// File: rtl/load_gen_lane.sv
// One 49-bit Fibonacci LFSR lane (taps 49/40). Shifts only while enabled,
// otherwise holds so an idle group burns no switching power.
module load_gen_lane
    import load_gen_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = LFSR_W'(1)
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              EN,
    input  logic              LOAD,
    input  logic [LFSR_W-1:0] LOAD_VAL,
    output logic              BIT_OUT
);

    logic [LFSR_W-1:0] state;

    // LFSR register: reset seed, optional reload, shift when enabled
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state <= SEED;
        end else if (LOAD) begin
            state <= LOAD_VAL;
        end else if (EN) begin
            state <= {state[TAP_HI-1:0], state[TAP_HI] ^ state[TAP_LO]};
        end
    end

    assign BIT_OUT = state[TAP_HI];

endmodule

// File: rtl/load_gen_ramp.sv
// Ramped switching-load generator: NUM_GROUPS groups of GROUP_WIDTH LFSR
// lanes, brought on and off one group per RAMP_STEP_CYC cycles so the
// current draw changes in controlled steps. Output is a registered parity
// of all active groups (lane bit to DATA_OUT: 2 cycles).
// Optional macro LOAD_GEN_SEED_LOAD_EN adds SEED_LOAD/SEED_VALUE for
// reseeding all lanes while IDLE.
module load_gen_ramp
    import load_gen_pkg::*;
#(
    parameter int                NUM_GROUPS    = 8,
    parameter int                GROUP_WIDTH   = 32,
    parameter int                RAMP_STEP_CYC = 4,
    parameter logic [LFSR_W-1:0] SEED_BASE     = 49'h1_55AA_AA55_55AA,
    localparam int               GW            = $clog2(NUM_GROUPS + 1)
) (
    input  logic          CLK,
    input  logic          RESET_N,
    input  logic          START,
    input  logic          STOP,
    input  logic [GW-1:0] TARGET_GROUPS,
    output logic          BUSY,
    output logic [GW-1:0] ACTIVE_GROUPS,
    output logic          DATA_OUT
`ifdef LOAD_GEN_SEED_LOAD_EN
    ,
    input  logic              SEED_LOAD,
    input  logic [LFSR_W-1:0] SEED_VALUE
`endif
);

    localparam int CW = $clog2(RAMP_STEP_CYC + 1);

    state_t            state, state_nxt;
    logic [CW-1:0]     cnt, cnt_nxt;
    logic [GW-1:0]     active, active_nxt;
    logic [GW-1:0]     target, target_nxt;
    logic [GW-1:0]     target_clamped;
    logic              step_wrap;

    logic              seed_load;
    logic [LFSR_W-1:0] seed_value;

    logic [GROUP_WIDTH-1:0] lane_bits [NUM_GROUPS];
    logic [NUM_GROUPS-1:0]  grp_en;
    logic [NUM_GROUPS-1:0]  grp_p0;
    logic                   data_p1;

`ifdef LOAD_GEN_SEED_LOAD_EN
    assign seed_load  = SEED_LOAD && (state == IDLE);
    assign seed_value = SEED_VALUE;
`else
    assign seed_load  = 1'b0;
    assign seed_value = '0;
`endif

    assign target_clamped = (TARGET_GROUPS > GW'(NUM_GROUPS)) ? GW'(NUM_GROUPS)
                                                              : TARGET_GROUPS;
    assign step_wrap      = (cnt == CW'(RAMP_STEP_CYC - 1));

    for (genvar g = 0; g < NUM_GROUPS; g++) begin : g_grp
        assign grp_en[g] = (GW'(g) < active);
        for (genvar b = 0; b < GROUP_WIDTH; b++) begin : g_lane
            localparam int unsigned LANE_IDX = g * GROUP_WIDTH + b;
            load_gen_lane #(
                .SEED(lane_seed(SEED_BASE, LANE_IDX))
            ) u_lane (
                .CLK     (CLK),
                .RESET_N (RESET_N),
                .EN      (grp_en[g]),
                .LOAD    (seed_load),
                .LOAD_VAL(lane_seed(seed_value, LANE_IDX)),
                .BIT_OUT (lane_bits[g][b])
            );
        end
    end

    // Ramp FSM state, step counter, active-group count and latched target
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state  <= IDLE;
            cnt    <= '0;
            active <= '0;
            target <= '0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            active <= active_nxt;
            target <= target_nxt;
        end
    end

    // Next-state logic; STOP always wins over START
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        active_nxt = active;
        target_nxt = target;
        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (START && !STOP && (target_clamped != '0)) begin
                    state_nxt  = RAMP_UP;
                    target_nxt = target_clamped;
                end
            end
            RAMP_UP: begin
                if (STOP) begin
                    state_nxt = RAMP_DOWN;
                    cnt_nxt   = '0;
                end else if (step_wrap) begin
                    cnt_nxt    = '0;
                    active_nxt = active + GW'(1);
                    if (active_nxt == target) begin
                        state_nxt = HOLD;
                    end
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            HOLD: begin
                cnt_nxt = '0;
                if (STOP) begin
                    state_nxt = RAMP_DOWN;
                end
            end
            RAMP_DOWN: begin
                if (step_wrap) begin
                    cnt_nxt = '0;
                    // Saturate: a stop before the first group came on leaves 0
                    if (active <= GW'(1)) begin
                        active_nxt = '0;
                        state_nxt  = IDLE;
                    end else begin
                        active_nxt = active - GW'(1);
                    end
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Stage p0: per-group XNOR reduction, forced to 0 for inactive groups
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            grp_p0 <= '0;
        end else begin
            for (int g = 0; g < NUM_GROUPS; g++) begin
                grp_p0[g] <= grp_en[g] ? ~^lane_bits[g] : 1'b0;
            end
        end
    end

    // Stage p1: parity of all group registers drives the output pin
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            data_p1 <= 1'b0;
        end else begin
            data_p1 <= ^grp_p0;
        end
    end

    assign DATA_OUT      = data_p1;
    assign BUSY          = (state != IDLE);
    assign ACTIVE_GROUPS = active;

endmodule

// File: tb/tb_load_gen_ramp.sv
// Bench for load_gen_ramp: a cycle model of FSM, lanes and output pipeline
// pushes expected outputs to a scoreboard queue each driven cycle; entries
// are popped and compared after the clock edge. Milestone checks with
// fixed constants cover the ramp timing.
module tb_load_gen_ramp;

    localparam int          NG  = 8;
    localparam int          GWD = 32;
    localparam int          RS  = 4;
    localparam logic [48:0] SB  = 49'h1_55AA_AA55_55AA;
    localparam int          AW  = $clog2(NG + 1);
    localparam int          NL  = NG * GWD;

    logic          CLK = 1'b0;
    logic          RESET_N;
    logic          START;
    logic          STOP;
    logic [AW-1:0] TARGET_GROUPS;
    logic          BUSY;
    logic [AW-1:0] ACTIVE_GROUPS;
    logic          DATA_OUT;
`ifdef LOAD_GEN_SEED_LOAD_EN
    logic          SEED_LOAD;
    logic [48:0]   SEED_VALUE;
`endif

    always #5 CLK = ~CLK;

    load_gen_ramp #(
        .NUM_GROUPS   (NG),
        .GROUP_WIDTH  (GWD),
        .RAMP_STEP_CYC(RS),
        .SEED_BASE    (SB)
    ) dut (
        .CLK          (CLK),
        .RESET_N      (RESET_N),
        .START        (START),
        .STOP         (STOP),
        .TARGET_GROUPS(TARGET_GROUPS),
        .BUSY         (BUSY),
        .ACTIVE_GROUPS(ACTIVE_GROUPS),
        .DATA_OUT     (DATA_OUT)
`ifdef LOAD_GEN_SEED_LOAD_EN
        ,
        .SEED_LOAD    (SEED_LOAD),
        .SEED_VALUE   (SEED_VALUE)
`endif
    );

    typedef struct {
        logic busy;
        int   act;
        logic data;
    } exp_t;

    exp_t        sb_q[$];
    int          total = 0;
    int          bad   = 0;

    // Reference model state (0=idle 1=ramp-up 2=hold 3=ramp-down)
    logic [48:0] m_lane [NL];
    logic [NG-1:0] m_grp = '0;
    logic        m_data = 1'b0;
    int          m_st   = 0;
    int          m_cnt  = 0;
    int          m_act  = 0;
    int          m_tgt  = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h at %0t", tag, got, want, $time);
        end
    endtask

    function automatic logic [48:0] seed_of(input int n);
        logic [48:0] s;
        s = SB + 49'(n) * 49'd7;
        if (s == 49'd0) s = 49'd1;
        return s;
    endfunction

    // Advance the model by one clock edge given the inputs driven before it
    task automatic model_step(input logic rn, input logic st, input logic sp, input int tg);
        logic [NG-1:0] grp_n;
        logic          data_n;
        logic          p;
        int            tc;
        if (!rn) begin
            for (int n = 0; n < NL; n++) m_lane[n] = seed_of(n);
            m_grp  = '0;
            m_data = 1'b0;
            m_st   = 0;
            m_cnt  = 0;
            m_act  = 0;
            m_tgt  = 0;
        end else begin
            data_n = ^m_grp;
            for (int g = 0; g < NG; g++) begin
                p = 1'b1;
                for (int b = 0; b < GWD; b++) p = p ^ m_lane[g*GWD+b][48];
                grp_n[g] = (g < m_act) ? p : 1'b0;
            end
            for (int g = 0; g < NG; g++) begin
                if (g < m_act) begin
                    for (int b = 0; b < GWD; b++) begin
                        m_lane[g*GWD+b] = {m_lane[g*GWD+b][47:0],
                                           m_lane[g*GWD+b][48] ^ m_lane[g*GWD+b][39]};
                    end
                end
            end
            m_grp  = grp_n;
            m_data = data_n;
            tc = (tg > NG) ? NG : tg;
            case (m_st)
                0: if (st && !sp && tc > 0) begin m_st = 1; m_tgt = tc; m_cnt = 0; end
                1: begin
                    if (sp) begin
                        m_st = 3; m_cnt = 0;
                    end else if (m_cnt == RS - 1) begin
                        m_cnt = 0; m_act++;
                        if (m_act == m_tgt) m_st = 2;
                    end else begin
                        m_cnt++;
                    end
                end
                2: if (sp) begin m_st = 3; m_cnt = 0; end
                default: begin
                    if (m_cnt == RS - 1) begin
                        m_cnt = 0;
                        if (m_act > 0) m_act--;
                        if (m_act == 0) m_st = 0;
                    end else begin
                        m_cnt++;
                    end
                end
            endcase
        end
    endtask

    // Drive one cycle of stimulus, queue the expectation, compare after the edge
    task automatic cycle(input logic rn, input logic st, input logic sp, input int tg);
        exp_t e;
        RESET_N       = rn;
        START         = st;
        STOP          = sp;
        TARGET_GROUPS = AW'(tg);
        model_step(rn, st, sp, tg);
        e.busy = (m_st != 0);
        e.act  = m_act;
        e.data = m_data;
        sb_q.push_back(e);
        @(posedge CLK);
        #1;
        if (sb_q.size() == 0) begin
            chk("sb_empty", 64'd1, 64'd0);
        end else begin
            e = sb_q.pop_front();
            chk("sb_busy",   64'(BUSY),          64'(e.busy));
            chk("sb_active", 64'(ACTIVE_GROUPS), 64'(e.act));
            chk("sb_data",   64'(DATA_OUT),      64'(e.data));
        end
        @(negedge CLK);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 1'b0, 0);
    endtask

    initial begin
        RESET_N       = 1'b0;
        START         = 1'b0;
        STOP          = 1'b0;
        TARGET_GROUPS = '0;
`ifdef LOAD_GEN_SEED_LOAD_EN
        SEED_LOAD     = 1'b0;
        SEED_VALUE    = '0;
`endif
        @(negedge CLK);

        // Reset
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0, 0);
        chk("rst_busy",   64'(BUSY),          64'd0);
        chk("rst_active", 64'(ACTIVE_GROUPS), 64'd0);
        chk("rst_data",   64'(DATA_OUT),      64'd0);
        idle(3);

        // START with zero target, START+STOP in IDLE, STOP in IDLE
        cycle(1'b1, 1'b1, 1'b0, 0);
        chk("tgt0_busy", 64'(BUSY), 64'd0);
        cycle(1'b1, 1'b1, 1'b1, 3);
        chk("startstop_busy", 64'(BUSY), 64'd0);
        cycle(1'b1, 1'b0, 1'b1, 0);
        chk("stop_idle_busy", 64'(BUSY), 64'd0);

        // Ramp to 3 groups, one step per 4 cycles
        cycle(1'b1, 1'b1, 1'b0, 3);
        chk("start_busy", 64'(BUSY), 64'd1);
        for (int i = 1; i <= 12; i++) begin
            idle(1);
            if (i == 4)  chk("up_k4",  64'(ACTIVE_GROUPS), 64'd1);
            if (i == 8)  chk("up_k8",  64'(ACTIVE_GROUPS), 64'd2);
            if (i == 12) chk("up_k12", 64'(ACTIVE_GROUPS), 64'd3);
        end
        cycle(1'b1, 1'b1, 1'b0, 5);
        idle(5);
        chk("hold_start_ignored", 64'(ACTIVE_GROUPS), 64'd3);

        // STOP from HOLD ramps down in the same steps
        cycle(1'b1, 1'b0, 1'b1, 0);
        for (int i = 1; i <= 12; i++) begin
            idle(1);
            if (i == 4)  chk("dn_m4",  64'(ACTIVE_GROUPS), 64'd2);
            if (i == 8)  chk("dn_m8",  64'(ACTIVE_GROUPS), 64'd1);
            if (i == 11) chk("dn_m11_busy", 64'(BUSY), 64'd1);
            if (i == 12) begin
                chk("dn_m12",      64'(ACTIVE_GROUPS), 64'd0);
                chk("dn_m12_busy", 64'(BUSY),          64'd0);
            end
        end

        // One group held for 100 cycles: group 0 streams, others hold state
        cycle(1'b1, 1'b1, 1'b0, 1);
        idle(4);
        chk("one_active", 64'(ACTIVE_GROUPS), 64'd1);
        idle(100);
        chk("one_hold", 64'(ACTIVE_GROUPS), 64'd1);
        cycle(1'b1, 1'b0, 1'b1, 0);
        idle(4);
        chk("one_off_busy", 64'(BUSY), 64'd0);

        // Target above NUM_GROUPS clamps to NUM_GROUPS
        cycle(1'b1, 1'b1, 1'b0, 15);
        idle(32);
        chk("clamp_active", 64'(ACTIVE_GROUPS), 64'd8);
        idle(10);
        chk("clamp_hold", 64'(ACTIVE_GROUPS), 64'd8);
        cycle(1'b1, 1'b0, 1'b1, 0);
        idle(32);
        chk("clamp_off_active", 64'(ACTIVE_GROUPS), 64'd0);
        chk("clamp_off_busy",   64'(BUSY),          64'd0);

        // STOP mid ramp-up with two groups on
        cycle(1'b1, 1'b1, 1'b0, 5);
        idle(8);
        chk("mid_active", 64'(ACTIVE_GROUPS), 64'd2);
        cycle(1'b1, 1'b1, 1'b1, 5);
        idle(7);
        chk("mid_busy7", 64'(BUSY), 64'd1);
        idle(1);
        chk("mid_off_active", 64'(ACTIVE_GROUPS), 64'd0);
        chk("mid_off_busy",   64'(BUSY),          64'd0);

        // STOP before any group came on
        cycle(1'b1, 1'b1, 1'b0, 3);
        cycle(1'b1, 1'b0, 1'b1, 0);
        idle(3);
        chk("early_busy", 64'(BUSY), 64'd1);
        idle(1);
        chk("early_off_busy", 64'(BUSY), 64'd0);

        // Reset mid-ramp returns straight to reset state and reseeds lanes
        cycle(1'b1, 1'b1, 1'b0, 4);
        idle(6);
        chk("pre_rst_active", 64'(ACTIVE_GROUPS), 64'd1);
        cycle(1'b0, 1'b0, 1'b0, 0);
        chk("midrst_active", 64'(ACTIVE_GROUPS), 64'd0);
        chk("midrst_busy",   64'(BUSY),          64'd0);
        chk("midrst_data",   64'(DATA_OUT),      64'd0);
        idle(3);
        cycle(1'b1, 1'b1, 1'b0, 2);
        idle(20);
        cycle(1'b1, 1'b0, 1'b1, 0);
        idle(10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/load_gen_ramp.md
Name: load_gen_ramp

Overview:
- Parametrised successor to the single-output LFSR load block.
- NUM_GROUPS groups of GROUP_WIDTH 49-bit LFSR lanes, each group gated by a run-time activity level.
- A ramp FSM brings groups on and off one at a time, so FPGA switching load (di/dt) rises and falls in controlled steps.
- Sits at the top of the load-test design and drives one parity output pin plus status.

Parameters:
- NUM_GROUPS, 8, number of lane groups (1..64).
- GROUP_WIDTH, 32, LFSR lanes per group (1..64).
- RAMP_STEP_CYC, 4, cycles between successive group enable/disable steps (>=1).
- SEED_BASE, 49'h1_55AA_AA55_55AA, seed of lane 0.

Ports:
- CLK  in  1  clock
- RESET_N  in  1  reset, synchronous, active-low
- START  in  1  start request, single-cycle pulse
- STOP  in  1  stop request, single-cycle pulse
- TARGET_GROUPS  in  GW=$clog2(NUM_GROUPS+1)  groups to enable; sampled on accepted START
- BUSY  out  1  high in any state other than IDLE
- ACTIVE_GROUPS  out  GW  groups currently enabled
- DATA_OUT  out  1  registered parity of all active group outputs

Behaviour:
- Reset (RESET_N=0 at posedge): every lane loads its seed; state IDLE; ACTIVE_GROUPS=0; BUSY=0; step counter=0; group regs=0; DATA_OUT=0.
- Lane seeds: lane n = g*GROUP_WIDTH+b loads (SEED_BASE + n*7) mod 2^49. A zero result is replaced by 1.
- LFSR update: Fibonacci form, taps 49 and 40. Update is s <= {s[47:0], s[48]^s[39]}; lane output is s[48].
- A lane shifts only while its group g < ACTIVE_GROUPS. Otherwise it holds its state.
- Group reg g: registered XNOR-reduction of its lanes when g < ACTIVE_GROUPS, else 0.
- DATA_OUT: registered XOR of all group regs. Latency from lane bit to DATA_OUT is 2 cycles.
- FSM states: IDLE, RAMP_UP, HOLD, RAMP_DOWN.
  - IDLE: START with clamped target >0 -> RAMP_UP. Target is min(TARGET_GROUPS, NUM_GROUPS), latched; counter cleared. START with target 0 is ignored.
  - RAMP_UP: counter counts 0..RAMP_STEP_CYC-1. On wrap, ACTIVE_GROUPS+=1. When the new value equals target -> HOLD on the same edge.
  - HOLD: ACTIVE_GROUPS is stable. START is ignored.
  - RAMP_DOWN: on counter wrap, ACTIVE_GROUPS-=1. When it reaches 0 -> IDLE on the same edge.
  - STOP in RAMP_UP or HOLD -> RAMP_DOWN, counter cleared, ACTIVE_GROUPS unchanged.
- Priority: STOP beats START in every state. START+STOP in IDLE leaves the FSM in IDLE. START outside IDLE is ignored. STOP in IDLE or RAMP_DOWN is ignored.
- Reset mid-ramp: immediate return to reset state. There is no ramp-down on reset.
- Counter width is $clog2(RAMP_STEP_CYC+1). With RAMP_STEP_CYC=1, ACTIVE_GROUPS steps every cycle.
- Lane state persists across runs and is not reseeded on START.

Optional Feature:
- Macro: LOAD_GEN_SEED_LOAD_EN.
- With the macro: adds ports SEED_LOAD (in, 1) and SEED_VALUE (in, 49).
  - SEED_LOAD=1 while in IDLE reloads lane n with SEED_VALUE + n*7, with the zero->1 rule applied.
  - SEED_LOAD is ignored outside IDLE. If SEED_LOAD coincides with an accepted START, the reload takes effect and START is accepted on the same edge.
- Without the macro: ports are absent; seeds come only from reset.

Decomposition:
- Package load_gen_pkg holds:
  - LFSR_W=49, TAP_HI=48, TAP_LO=39, SEED_STRIDE=7;
  - the state enum;
  - a seed function (base, lane index) -> nonzero 49-bit seed.
- Sub-module load_gen_lane: one LFSR with inputs CLK, RESET_N, EN, LOAD, LOAD_VAL, SEED (parameter) and output BIT_OUT.
- The top level holds the FSM, the counter, group reduction and the output parity.

Test Plan:
- Reset with defaults -> DATA_OUT=0, BUSY=0, ACTIVE_GROUPS=0; all lane states equal SEED_BASE+n*7.
- START at edge k with TARGET_GROUPS=3, RAMP_STEP_CYC=4 -> BUSY=1 from k; ACTIVE_GROUPS=1 at k+4, 2 at k+8, 3 at k+12; HOLD at k+12.
- STOP at HOLD edge m -> ACTIVE_GROUPS=2 at m+4, 1 at m+8, 0 at m+12; IDLE and BUSY=0 at m+12.
- TARGET_GROUPS=15 with NUM_GROUPS=8 -> ramps to 8 and holds. TARGET_GROUPS=0 -> START ignored, BUSY stays 0.
- START+STOP together in IDLE -> stays IDLE. STOP at RAMP_UP with ACTIVE_GROUPS=2 -> RAMP_DOWN; reaches 0 after 8 cycles.
- ACTIVE_GROUPS=1 in HOLD for 100 cycles:
  - group-1 lanes stay unchanged;
  - lane 0 bit stream matches the golden taps-49/40 model;
  - DATA_OUT equals the XNOR of group 0 delayed 2 cycles.
